mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory access stage: issues one load/store at a time to the data memory,
// stalls upstream while the access is outstanding and produces a registered writeback slot.
module mem_stage #(
    parameter int unsigned WAIT_LIMIT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_result,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic        flush,
    output logic        mem_stall,
    output logic [31:0] dmem_addr,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_fault
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int unsigned CW = (WAIT_LIMIT > 32'd1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LIMIT_M1 = CW'((WAIT_LIMIT > 32'd0) ? WAIT_LIMIT - 32'd1 : 32'd0);

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] base;
        case (funct3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            2'b10:   base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] ext;
        case (funct3)
            3'b000:  ext = {{24{data[7]}}, data[7:0]};
            3'b001:  ext = {{16{data[15]}}, data[15:0]};
            3'b100:  ext = {24'd0, data[7:0]};
            3'b101:  ext = {16'd0, data[15:0]};
            default: ext = data;
        endcase
        return ext;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic           kill_r;
    logic [31:0]    addr_r, wdata_r;
    logic [3:0]     mask_r;
    logic           store_r, we_r;
    logic [2:0]     funct3_r;
    logic [4:0]     rd_r;
    logic [1:0]     off_r;

    logic           busy_s, mem_op_s, misal_s, accept_s, timeout_s, kill_now_s;
    logic [31:0]    load_data_s;

    assign busy_s      = (state_r == BUSY);
    assign mem_op_s    = in_valid & ~flush & (in_load | in_store);
    assign misal_s     = is_misaligned(in_funct3, in_addr[1:0]);
    // rst gates the accept so no stall can be raised while reset is held
    assign accept_s    = rst & ~busy_s & mem_op_s & ~misal_s;
    assign timeout_s   = (WAIT_LIMIT != 32'd0) && busy_s && !dmem_resp && (cnt_r == LIMIT_M1);
    assign kill_now_s  = kill_r | flush;
    assign load_data_s = load_extend(funct3_r, dmem_rdata >> {off_r, 3'b000});

    // Next state and memory-side / stall outputs
    always_comb begin
        state_nxt_s = state_r;
        mem_stall   = 1'b0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        dmem_rmask  = 4'b0000;
        dmem_wmask  = 4'b0000;
        dmem_addr   = addr_r;
        dmem_wdata  = wdata_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                    mem_stall   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                dmem_read  = ~store_r;
                dmem_write = store_r;
                dmem_rmask = store_r ? 4'b0000 : mask_r;
                dmem_wmask = store_r ? mask_r : 4'b0000;
                if (dmem_resp || timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, wait counter and sticky kill bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r <= '0;
            end else if (busy_s) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (busy_s && !dmem_resp && !timeout_s) begin
                kill_r <= kill_r | flush;
            end else begin
                kill_r <= 1'b0;
            end
        end
    end

    // Request latches captured on accept; BUSY drives memory only from these
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            mask_r   <= 4'd0;
            store_r  <= 1'b0;
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            rd_r     <= 5'd0;
            off_r    <= 2'd0;
        end else if (accept_s) begin
            addr_r   <= {in_addr[31:2], 2'b00};
            wdata_r  <= in_wdata << {in_addr[1:0], 3'b000};
            mask_r   <= byte_mask(in_funct3, in_addr[1:0]);
            store_r  <= in_store;
            we_r     <= ~in_store & in_regwrite & (in_rd != 5'd0);
            funct3_r <= in_funct3;
            rd_r     <= in_rd;
            off_r    <= in_addr[1:0];
        end
    end

    // Writeback slot; rd and data hold whenever the slot is not filled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            wb_fault <= 1'b0;
        end else if (busy_s) begin
            if ((dmem_resp || timeout_s) && !kill_now_s) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_r;
                wb_fault <= timeout_s;
                wb_we    <= we_r & ~timeout_s;
                if (!timeout_s) begin
                    wb_data <= store_r ? 32'd0 : load_data_s;
                end
            end else begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
                wb_fault <= 1'b0;
            end
        end else if (in_valid && !flush) begin
            if (in_load || in_store) begin
                wb_valid <= misal_s;
                wb_fault <= misal_s;
                wb_we    <= 1'b0;
                if (misal_s) begin
                    wb_rd <= in_rd;
                end
            end else begin
                wb_valid <= 1'b1;
                wb_fault <= 1'b0;
                wb_we    <= in_regwrite & (in_rd != 5'd0);
                wb_rd    <= in_rd;
                wb_data  <= in_result;
            end
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one instance without timeout,
// one with WAIT_LIMIT=4, both driven from the same upstream/memory stimulus.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_load, in_store, in_regwrite, flush, dmem_resp;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_result, dmem_rdata;
    logic [4:0]  in_rd;

    logic        d0_mem_stall, d0_dmem_read, d0_dmem_write, d0_wb_valid, d0_wb_we, d0_wb_fault;
    logic [31:0] d0_dmem_addr, d0_dmem_wdata, d0_wb_data;
    logic [3:0]  d0_dmem_rmask, d0_dmem_wmask;
    logic [4:0]  d0_wb_rd;
    logic        d4_mem_stall, d4_dmem_read, d4_dmem_write, d4_wb_valid, d4_wb_we, d4_wb_fault;
    logic [31:0] d4_dmem_addr, d4_dmem_wdata, d4_wb_data;
    logic [3:0]  d4_dmem_rmask, d4_dmem_wmask;
    logic [4:0]  d4_wb_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush), .mem_stall(d0_mem_stall),
        .dmem_addr(d0_dmem_addr), .dmem_read(d0_dmem_read), .dmem_write(d0_dmem_write),
        .dmem_rmask(d0_dmem_rmask), .dmem_wmask(d0_dmem_wmask), .dmem_wdata(d0_dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .wb_valid(d0_wb_valid), .wb_we(d0_wb_we),
        .wb_rd(d0_wb_rd), .wb_data(d0_wb_data), .wb_fault(d0_wb_fault)
    );

    mem_stage #(.WAIT_LIMIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush), .mem_stall(d4_mem_stall),
        .dmem_addr(d4_dmem_addr), .dmem_read(d4_dmem_read), .dmem_write(d4_dmem_write),
        .dmem_rmask(d4_dmem_rmask), .dmem_wmask(d4_dmem_wmask), .dmem_wdata(d4_dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .wb_valid(d4_wb_valid), .wb_we(d4_wb_we),
        .wb_rd(d4_wb_rd), .wb_data(d4_wb_data), .wb_fault(d4_wb_fault)
    );

    task automatic drive_idle();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_regwrite = 1'b0; flush = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_result = 32'd0; in_rd = 5'd0;
        dmem_rdata = 32'd0; dmem_resp = 1'b0;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_regwrite = 1'b1;
        in_funct3 = f3; in_addr = addr; in_rd = rd;
    endtask

    task automatic test_reset();
        drive_idle();
        #3 rst = 1'b0;
        drive_load(3'b010, 32'h0000_0100, 5'd1);
        #1;
        checks++; if (d0_mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", d0_mem_stall); end
        checks++; if (d4_mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall4: got %b want 0", d4_mem_stall); end
        checks++; if (d0_dmem_rmask !== 4'b0000) begin errors++; $display("FAIL reset_rmask: got %b want 0000", d0_dmem_rmask); end
        checks++; if ({d0_wb_valid, d0_wb_we, d0_wb_fault, d0_wb_rd, d0_wb_data} !== 40'd0) begin
            errors++; $display("FAIL reset_wb: got v=%b rd=%0d data=%h want all zero", d0_wb_valid, d0_wb_rd, d0_wb_data); end
        @(posedge clk); #1;
        checks++; if (d0_dmem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", d0_dmem_read); end
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        drive_load(3'b000, 32'h0000_1003, 5'd5);
        #3;
        checks++; if (d0_mem_stall !== 1'b1) begin errors++; $display("FAIL lb_accept_stall: got %b want 1", d0_mem_stall); end
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        #3;
        checks++; if (d0_dmem_read !== 1'b1 || d0_dmem_write !== 1'b0) begin
            errors++; $display("FAIL lb_req: got rd=%b wr=%b want rd=1 wr=0", d0_dmem_read, d0_dmem_write); end
        checks++; if (d0_dmem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", d0_dmem_addr); end
        checks++; if (d0_dmem_rmask !== 4'b1000) begin errors++; $display("FAIL lb_rmask: got %b want 1000", d0_dmem_rmask); end
        checks++; if (d0_mem_stall !== 1'b0) begin errors++; $display("FAIL lb_resp_stall: got %b want 0", d0_mem_stall); end
        checks++; if (d0_wb_valid !== 1'b0) begin errors++; $display("FAIL lb_early_valid: got %b want 0", d0_wb_valid); end
        @(posedge clk); #1;
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b1 || d0_wb_we !== 1'b1 || d0_wb_fault !== 1'b0 || d0_wb_rd !== 5'd5) begin
            errors++; $display("FAIL lb_wb_ctl: got v=%b we=%b f=%b rd=%0d want 1 1 0 5", d0_wb_valid, d0_wb_we, d0_wb_fault, d0_wb_rd); end
        checks++; if (d0_wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data: got %h want ffffff80", d0_wb_data); end
        @(posedge clk); #1;
        checks++; if (d0_wb_valid !== 1'b0) begin errors++; $display("FAIL lb_idle_valid: got %b want 0", d0_wb_valid); end
        checks++; if (d0_wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_idle_hold: got %h want ffffff80", d0_wb_data); end
    endtask

    task automatic test_sh();
        in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b001; in_addr = 32'h0000_2002;
        in_wdata = 32'h0000_BEEF; in_rd = 5'd0;
        #3;
        checks++; if (d0_mem_stall !== 1'b1) begin errors++; $display("FAIL sh_accept_stall: got %b want 1", d0_mem_stall); end
        @(posedge clk); #1; #3;
        checks++; if (d0_dmem_write !== 1'b1 || d0_dmem_read !== 1'b0) begin
            errors++; $display("FAIL sh_req: got wr=%b rd=%b want wr=1 rd=0", d0_dmem_write, d0_dmem_read); end
        checks++; if (d0_dmem_wmask !== 4'b1100 || d0_dmem_rmask !== 4'b0000) begin
            errors++; $display("FAIL sh_mask: got w=%b r=%b want w=1100 r=0000", d0_dmem_wmask, d0_dmem_rmask); end
        checks++; if (d0_dmem_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_wdata: got %h want beef0000", d0_dmem_wdata); end
        checks++; if (d0_dmem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", d0_dmem_addr); end
        checks++; if (d0_mem_stall !== 1'b1) begin errors++; $display("FAIL sh_wait_stall: got %b want 1", d0_mem_stall); end
        @(posedge clk); #1;
        dmem_resp = 1'b1;
        #3;
        checks++; if (d0_mem_stall !== 1'b0) begin errors++; $display("FAIL sh_resp_stall: got %b want 0", d0_mem_stall); end
        @(posedge clk); #1;
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b1 || d0_wb_we !== 1'b0 || d0_wb_data !== 32'd0) begin
            errors++; $display("FAIL sh_wb: got v=%b we=%b data=%h want 1 0 00000000", d0_wb_valid, d0_wb_we, d0_wb_data); end
    endtask

    task automatic test_misaligned();
        drive_load(3'b010, 32'h0000_3001, 5'd3);
        #3;
        checks++; if (d0_mem_stall !== 1'b0 || d0_dmem_read !== 1'b0 || d0_dmem_write !== 1'b0) begin
            errors++; $display("FAIL lw_mis_req: got stall=%b rd=%b wr=%b want 0 0 0", d0_mem_stall, d0_dmem_read, d0_dmem_write); end
        @(posedge clk); #1;
        in_load = 1'b0; in_store = 1'b1; in_funct3 = 3'b001; in_addr = 32'h0000_3003;
        checks++; if (d0_wb_valid !== 1'b1 || d0_wb_fault !== 1'b1 || d0_wb_we !== 1'b0) begin
            errors++; $display("FAIL lw_mis_wb: got v=%b f=%b we=%b want 1 1 0", d0_wb_valid, d0_wb_fault, d0_wb_we); end
        #3;
        checks++; if (d0_dmem_write !== 1'b0 || d0_mem_stall !== 1'b0) begin
            errors++; $display("FAIL sh_mis_req: got wr=%b stall=%b want 0 0", d0_dmem_write, d0_mem_stall); end
        @(posedge clk); #1;
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b1 || d0_wb_fault !== 1'b1) begin
            errors++; $display("FAIL sh_mis_wb: got v=%b f=%b want 1 1", d0_wb_valid, d0_wb_fault); end
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        logic [31:0] res [3] = '{32'h1234_5678, 32'hA5A5_A5A5, 32'h0BAD_F00D};
        logic [4:0]  rds [3] = '{5'd7, 5'd0, 5'd9};
        logic        rws [3] = '{1'b1, 1'b1, 1'b0};
        logic        wes [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_result = res[i]; in_rd = rds[i]; in_regwrite = rws[i];
            #3;
            checks++; if (d0_mem_stall !== 1'b0) begin errors++; $display("FAIL alu%0d_stall: got %b want 0", i, d0_mem_stall); end
            @(posedge clk); #1;
            checks++; if (d0_wb_valid !== 1'b1 || d0_wb_data !== res[i] || d0_wb_we !== wes[i] || d0_wb_rd !== rds[i]) begin
                errors++; $display("FAIL alu%0d_wb: got v=%b data=%h we=%b rd=%0d want 1 %h %b %0d",
                                   i, d0_wb_valid, d0_wb_data, d0_wb_we, d0_wb_rd, res[i], wes[i], rds[i]); end
        end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_flush_idle();
        in_valid = 1'b1; in_result = 32'h0000_0055; in_rd = 5'd4; in_regwrite = 1'b1;
        @(posedge clk); #1;
        drive_load(3'b010, 32'h0000_6000, 5'd4);
        flush = 1'b1;
        #3;
        checks++; if (d0_mem_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", d0_mem_stall); end
        @(posedge clk); #1;
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b0 || d0_dmem_read !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got v=%b rd=%b want 0 0", d0_wb_valid, d0_dmem_read); end
        checks++; if (d0_wb_data !== 32'h0000_0055) begin errors++; $display("FAIL flush_idle_hold: got %h want 00000055", d0_wb_data); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] adrs [5] = '{32'h1001, 32'h1000, 32'h1002, 32'h1004, 32'h1001};
        logic [31:0] rdat [5] = '{32'h0000_A500, 32'h0000_8001, 32'hBEEF_0000, 32'hCAFE_BABE, 32'h0000_7F00};
        logic [31:0] exps [5] = '{32'h0000_00A5, 32'hFFFF_8001, 32'h0000_BEEF, 32'hCAFE_BABE, 32'h0000_007F};
        logic [3:0]  msks [5] = '{4'b0010, 4'b0011, 4'b1100, 4'b1111, 4'b0010};
        logic [31:0] wadr [5] = '{32'h1000, 32'h1000, 32'h1000, 32'h1004, 32'h1000};
        for (int i = 0; i < 5; i++) begin
            drive_load(f3s[i], adrs[i], 5'd10);
            @(posedge clk); #1;
            dmem_resp = 1'b1; dmem_rdata = rdat[i];
            #3;
            checks++; if (d0_dmem_rmask !== msks[i] || d0_dmem_addr !== wadr[i]) begin
                errors++; $display("FAIL ld%0d_req: got mask=%b addr=%h want %b %h", i, d0_dmem_rmask, d0_dmem_addr, msks[i], wadr[i]); end
            @(posedge clk); #1;
            drive_idle();
            checks++; if (d0_wb_valid !== 1'b1 || d0_wb_data !== exps[i]) begin
                errors++; $display("FAIL ld%0d_data: got v=%b data=%h want 1 %h", i, d0_wb_valid, d0_wb_data, exps[i]); end
        end
    endtask

    task automatic test_flush_busy();
        drive_load(3'b101, 32'h0000_4002, 5'd6);
        @(posedge clk); #1;
        for (int c = 1; c <= 5; c++) begin
            flush = (c == 2);
            dmem_resp = (c == 5);
            dmem_rdata = 32'hBEEF_0000;
            #3;
            checks++; if (d0_dmem_read !== 1'b1) begin errors++; $display("FAIL fb_hold_c%0d: got rd=%b want 1", c, d0_dmem_read); end
            checks++; if (d0_mem_stall !== (c != 5)) begin errors++; $display("FAIL fb_stall_c%0d: got %b want %b", c, d0_mem_stall, (c != 5)); end
            @(posedge clk); #1;
        end
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b0 || d0_wb_we !== 1'b0) begin
            errors++; $display("FAIL fb_killed: got v=%b we=%b want 0 0", d0_wb_valid, d0_wb_we); end
        checks++; if (d0_wb_data !== 32'h0000_007F) begin errors++; $display("FAIL fb_hold_data: got %h want 0000007f", d0_wb_data); end
        drive_load(3'b101, 32'h0000_4002, 5'd6);
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hBEEF_0000;
        @(posedge clk); #1;
        drive_idle();
        checks++; if (d0_wb_valid !== 1'b1 || d0_wb_data !== 32'h0000_BEEF) begin
            errors++; $display("FAIL fb_after: got v=%b data=%h want 1 0000beef", d0_wb_valid, d0_wb_data); end
    endtask

    task automatic test_timeout_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        drive_load(3'b010, 32'h0000_5000, 5'd8);
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            #3;
            checks++; if (d4_dmem_read !== 1'b1) begin errors++; $display("FAIL to_req_c%0d: got %b want 1", c, d4_dmem_read); end
            @(posedge clk); #1;
        end
        drive_idle();
        checks++; if (d4_wb_valid !== 1'b1 || d4_wb_fault !== 1'b1 || d4_wb_we !== 1'b0) begin
            errors++; $display("FAIL to_wb: got v=%b f=%b we=%b want 1 1 0", d4_wb_valid, d4_wb_fault, d4_wb_we); end
        #1;
        checks++; if (d4_dmem_read !== 1'b0) begin errors++; $display("FAIL to_drop: got %b want 0", d4_dmem_read); end
        checks++; if (d0_dmem_read !== 1'b1 || d0_mem_stall !== 1'b1) begin
            errors++; $display("FAIL nolimit_wait: got rd=%b stall=%b want 1 1", d0_dmem_read, d0_mem_stall); end
        rst = 1'b0;
        #1;
        checks++; if (d0_dmem_read !== 1'b0 || d0_mem_stall !== 1'b0 || d0_dmem_rmask !== 4'b0000 || d0_dmem_addr !== 32'd0) begin
            errors++; $display("FAIL rst_busy_mem: got rd=%b stall=%b mask=%b addr=%h want all zero",
                               d0_dmem_read, d0_mem_stall, d0_dmem_rmask, d0_dmem_addr); end
        checks++; if (d4_wb_valid !== 1'b0 || d4_wb_fault !== 1'b0 || d0_wb_data !== 32'd0) begin
            errors++; $display("FAIL rst_busy_wb: got v=%b f=%b data=%h want 0 0 0", d4_wb_valid, d4_wb_fault, d0_wb_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (d0_wb_valid !== 1'b0 || d0_dmem_read !== 1'b0) begin
            errors++; $display("FAIL rst_no_wb: got v=%b rd=%b want 0 0", d0_wb_valid, d0_dmem_read); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_nonmem();
        test_flush_idle();
        test_loads();
        test_flush_busy();
        test_timeout_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
